// File: rtl/vga_timing_gen.sv
// Raster timing generator: nested pixel/line counters advanced by a pixel-tick enable, with genlock resync.
// Every output is registered and derived from the next counter state, so levels always agree with o_x/o_y.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_ACT = 0,
  parameter int V_SYNC_ACT = 0,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 10
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_px_clk,
  input  logic              i_resync,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_vblank,
  output logic [X_BITS-1:0] o_x,
  output logic [Y_BITS-1:0] o_y,
  output logic              o_line_start,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [X_BITS-1:0] X_LAST    = X_BITS'(H_TOTAL - 1);
  localparam logic [X_BITS-1:0] X_VIS     = X_BITS'(H_VISIBLE);
  localparam logic [X_BITS-1:0] X_SYNC_LO = X_BITS'(H_VISIBLE + H_FRONT);
  localparam logic [X_BITS-1:0] X_SYNC_HI = X_BITS'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [Y_BITS-1:0] Y_LAST    = Y_BITS'(V_TOTAL - 1);
  localparam logic [Y_BITS-1:0] Y_VIS     = Y_BITS'(V_VISIBLE);
  localparam logic [Y_BITS-1:0] Y_SYNC_LO = Y_BITS'(V_VISIBLE + V_FRONT);
  localparam logic [Y_BITS-1:0] Y_SYNC_HI = Y_BITS'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic HS_ON = (H_SYNC_ACT != 0);
  localparam logic VS_ON = (V_SYNC_ACT != 0);

  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic pend_q, pend_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic vblank_q, vblank_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    pend_d = pend_q | i_resync;
    if (i_px_clk) begin
      pend_d = 1'b0;
      // A resync landing on the natural wrap yields the same single (0,0) entry.
      if (i_resync || pend_q) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + Y_BITS'(1);
      end else begin
        x_d = x_q + X_BITS'(1);
      end
    end

    line_start_d  = i_px_clk && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
    de_d          = (x_d < X_VIS) && (y_d < Y_VIS);
    vblank_d      = (y_d >= Y_VIS);
    hsync_d       = ((x_d >= X_SYNC_LO) && (x_d < X_SYNC_HI)) ? HS_ON : ~HS_ON;
    vsync_d       = ((y_d >= Y_SYNC_LO) && (y_d < Y_SYNC_HI)) ? VS_ON : ~VS_ON;
  end

  // Reset parks on the last pixel of the frame so the first tick enters (0,0) with both strobes.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      pend_q        <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      de_q          <= 1'b0;
      vblank_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      pend_q        <= pend_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_de          = de_q;
  assign o_vblank      = vblank_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance for line-level timing, resync and reset,
// plus a tiny instance with active-high syncs for whole-frame timing and the wrap/resync corner.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  // Default instance
  logic rst_d = 1'b0, px_d = 1'b0, rs_d = 1'b0;
  logic [9:0] d_x, d_y;
  logic d_hs, d_vs, d_de, d_vb, d_ls, d_fs;
  logic [25:0] dv;
  assign dv = {d_x, d_y, d_de, d_vb, d_hs, d_vs, d_ls, d_fs};

  vga_timing_gen u_def (
    .clk(clk), .i_rst_n(rst_d), .i_px_clk(px_d), .i_resync(rs_d),
    .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de), .o_vblank(d_vb),
    .o_x(d_x), .o_y(d_y), .o_line_start(d_ls), .o_frame_start(d_fs)
  );

  // Small instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), active-high syncs
  logic rst_s = 1'b0, px_s = 1'b0, rs_s = 1'b0;
  logic [2:0] s_x, s_y;
  logic s_hs, s_vs, s_de, s_vb, s_ls, s_fs;
  logic [11:0] sv;
  assign sv = {s_x, s_y, s_de, s_vb, s_hs, s_vs, s_ls, s_fs};

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_ACT(1), .V_SYNC_ACT(1), .X_BITS(3), .Y_BITS(3)
  ) u_sml (
    .clk(clk), .i_rst_n(rst_s), .i_px_clk(px_s), .i_resync(rs_s),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de), .o_vblank(s_vb),
    .o_x(s_x), .o_y(s_y), .o_line_start(s_ls), .o_frame_start(s_fs)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_d = 1'b0; rst_s = 1'b0; px_d = 1'b0; px_s = 1'b0; rs_d = 1'b0; rs_s = 1'b0;
    tick(2);
    nchk++;
    if (dv !== {10'd799, 10'd524, 6'b011100}) begin
      nfail++; $display("FAIL reset_def: got %h want %h", dv, {10'd799, 10'd524, 6'b011100});
    end
    nchk++;
    if (sv !== {3'd7, 3'd5, 6'b010000}) begin
      nfail++; $display("FAIL reset_sml: got %h want %h", sv, {3'd7, 3'd5, 6'b010000});
    end
  endtask

  task automatic test_first_tick;
    rst_d = 1'b1;
    tick(3);
    nchk++;
    if (dv !== {10'd799, 10'd524, 6'b011100}) begin
      nfail++; $display("FAIL idle_after_release: got %h want %h", dv, {10'd799, 10'd524, 6'b011100});
    end
    px_d = 1'b1;
    tick(1);
    px_d = 1'b0;
    nchk++;
    if (dv !== {10'd0, 10'd0, 6'b101111}) begin
      nfail++; $display("FAIL first_tick: got %h want %h", dv, {10'd0, 10'd0, 6'b101111});
    end
    tick(1);
    nchk++;
    if (dv !== {10'd0, 10'd0, 6'b101100}) begin
      nfail++; $display("FAIL strobe_drop_no_tick: got %h want %h", dv, {10'd0, 10'd0, 6'b101100});
    end
  endtask

  task automatic test_hsync_line;
    int hs_low = 0, hs_first = -1, hs_last = -1, de_cnt = 0, ls_cnt = 0, fs_cnt = 0;
    px_d = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      tick(1);
      if (d_hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (d_de) de_cnt++;
      if (d_ls) ls_cnt++;
      if (d_fs) fs_cnt++;
    end
    nchk++;
    if (hs_low != 96 || hs_first != 656 || hs_last != 751) begin
      nfail++; $display("FAIL hsync_window: got %0d clk x=%0d..%0d want 96 clk x=656..751", hs_low, hs_first, hs_last);
    end
    nchk++;
    if (de_cnt != 640) begin
      nfail++; $display("FAIL de_per_line: got %0d want 640", de_cnt);
    end
    nchk++;
    if (ls_cnt != 1 || fs_cnt != 0) begin
      nfail++; $display("FAIL line_wrap_strobes: got ls=%0d fs=%0d want ls=1 fs=0", ls_cnt, fs_cnt);
    end
    nchk++;
    if (dv !== {10'd0, 10'd1, 6'b101110}) begin
      nfail++; $display("FAIL line_wrap_state: got %h want %h", dv, {10'd0, 10'd1, 6'b101110});
    end
  endtask

  task automatic test_resync_tick;
    tick(300);
    nchk++;
    if ({d_x, d_y} !== {10'd300, 10'd1}) begin
      nfail++; $display("FAIL pre_resync_pos: got x=%0d y=%0d want x=300 y=1", d_x, d_y);
    end
    rs_d = 1'b1;
    tick(1);
    rs_d = 1'b0;
    nchk++;
    if (dv !== {10'd0, 10'd0, 6'b101111}) begin
      nfail++; $display("FAIL resync_on_tick: got %h want %h", dv, {10'd0, 10'd0, 6'b101111});
    end
    tick(1);
    nchk++;
    if (dv !== {10'd1, 10'd0, 6'b101100}) begin
      nfail++; $display("FAIL after_resync: got %h want %h", dv, {10'd1, 10'd0, 6'b101100});
    end
  endtask

  task automatic test_resync_pending;
    tick(9);
    px_d = 1'b0;
    rs_d = 1'b1; tick(1);
    rs_d = 1'b0; tick(1);
    rs_d = 1'b1; tick(1);
    rs_d = 1'b0; tick(2);
    nchk++;
    if (dv !== {10'd10, 10'd0, 6'b101100}) begin
      nfail++; $display("FAIL pending_holds: got %h want %h", dv, {10'd10, 10'd0, 6'b101100});
    end
    px_d = 1'b1;
    tick(1);
    nchk++;
    if (dv !== {10'd0, 10'd0, 6'b101111}) begin
      nfail++; $display("FAIL pending_applied: got %h want %h", dv, {10'd0, 10'd0, 6'b101111});
    end
    tick(1);
    nchk++;
    if (dv !== {10'd1, 10'd0, 6'b101100}) begin
      nfail++; $display("FAIL pending_cleared: got %h want %h", dv, {10'd1, 10'd0, 6'b101100});
    end
  endtask

  task automatic test_reset_mid;
    tick(699);
    nchk++;
    if (dv !== {10'd700, 10'd0, 6'b000100}) begin
      nfail++; $display("FAIL in_hsync: got %h want %h", dv, {10'd700, 10'd0, 6'b000100});
    end
    #1 rst_d = 1'b0;
    #1;
    nchk++;
    if (dv !== {10'd799, 10'd524, 6'b011100}) begin
      nfail++; $display("FAIL async_reset: got %h want %h", dv, {10'd799, 10'd524, 6'b011100});
    end
    tick(1);
    nchk++;
    if (dv !== {10'd799, 10'd524, 6'b011100}) begin
      nfail++; $display("FAIL reset_held: got %h want %h", dv, {10'd799, 10'd524, 6'b011100});
    end
    rst_d = 1'b1;
    tick(1);
    px_d = 1'b0;
    nchk++;
    if (dv !== {10'd0, 10'd0, 6'b101111}) begin
      nfail++; $display("FAIL restart_after_reset: got %h want %h", dv, {10'd0, 10'd0, 6'b101111});
    end
  endtask

  // Tiny frame with a tick every third clk, checked cycle by cycle against a counting model.
  task automatic test_small_frame;
    int mx = 7, my = 5, last_fs = -1, fs_cnt = 0;
    logic tk;
    logic [11:0] exp_v;
    rst_s = 1'b1;
    tick(1);
    for (int c = 0; c < 300; c++) begin
      tk = (c % 3 == 0);
      px_s = tk;
      tick(1);
      if (tk) begin
        if (mx == 7) begin
          mx = 0;
          my = (my == 5) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      exp_v = {3'(mx), 3'(my), (mx < 4 && my < 3), (my >= 3), (mx >= 5 && mx < 7),
               (my == 4), (tk && mx == 0), (tk && mx == 0 && my == 0)};
      nchk++;
      if (sv !== exp_v) begin
        nfail++; $display("FAIL small_cycle_%0d: got %h want %h", c, sv, exp_v);
      end
      if (s_fs) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          nchk++;
          if (c - last_fs != 144) begin
            nfail++; $display("FAIL small_frame_period: got %0d want 144", c - last_fs);
          end
        end
        last_fs = c;
      end
    end
    px_s = 1'b0;
    nchk++;
    if (fs_cnt != 3) begin
      nfail++; $display("FAIL small_frame_count: got %0d want 3", fs_cnt);
    end
  endtask

  task automatic test_small_resync_wrap;
    int budget = 0, fs_cnt = 0;
    px_s = 1'b1;
    while (!(s_x == 3'd7 && s_y == 3'd5) && budget < 100) begin
      tick(1);
      budget++;
    end
    nchk++;
    if (budget >= 100) begin
      nfail++; $display("FAIL reach_wrap: got timeout at x=%0d y=%0d want x=7 y=5", s_x, s_y);
    end
    rs_s = 1'b1;
    tick(1);
    rs_s = 1'b0;
    nchk++;
    if (sv !== {3'd0, 3'd0, 6'b100011}) begin
      nfail++; $display("FAIL wrap_resync_state: got %h want %h", sv, {3'd0, 3'd0, 6'b100011});
    end
    if (s_fs) fs_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (s_fs) fs_cnt++;
    end
    px_s = 1'b0;
    nchk++;
    if (fs_cnt != 1) begin
      nfail++; $display("FAIL wrap_resync_single: got %0d pulses want 1", fs_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_hsync_line();
    test_resync_tick();
    test_resync_pending();
    test_reset_mid();
    test_small_frame();
    test_small_resync_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator that replaces the fixed 640x480 vertical-only sync counter.
- Generates both horizontal and vertical timing from two nested counters (pixel within line, line within frame) advanced by a pixel-clock enable.
- Outputs polarity-programmable sync, data-enable, blanking, pixel coordinates, line/frame start strobes.
- Supports a genlock resync input.
- Sits between the pixel-clock divider and the framebuffer address/pixel pipeline.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_ACT, 0, active level of o_hsync (0 = active-low)
V_SYNC_ACT, 0, active level of o_vsync
X_BITS, 10, coordinate width; 2^X_BITS >= H_TOTAL required
Y_BITS, 10, line coordinate width; 2^Y_BITS >= V_TOTAL required

Derived: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. All field parameters are >= 1.

Ports:
clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_px_clk  input  1  pixel-tick enable; counters advance only on clk edges with i_px_clk=1
i_resync  input  1  request restart at pixel (0,0)
o_hsync  output  1  horizontal sync, polarity per H_SYNC_ACT
o_vsync  output  1  vertical sync, polarity per V_SYNC_ACT
o_de  output  1  data enable: visible pixel
o_vblank  output  1  line counter outside visible lines
o_x  output  X_BITS  current pixel counter (0..H_TOTAL-1)
o_y  output  Y_BITS  current line counter (0..V_TOTAL-1)
o_line_start  output  1  one-clk strobe on entry to pixel 0 of any line
o_frame_start  output  1  one-clk strobe on entry to (0,0)

Behaviour:
- Counter order per line: visible [0, H_VISIBLE), front porch, sync [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), back porch. The vertical counter uses the same order in lines.
- On a tick (i_px_clk=1):
  - x increments.
  - At x = H_TOTAL-1, x wraps to 0 and y increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- No tick: all counters and level outputs hold. Strobes drop to 0.
- All outputs are registers, with no combinational path from inputs to outputs.
  - Outputs are computed from the next counter value, so o_hsync/o_vsync/o_de/o_vblank always match o_x/o_y in the same cycle.
  - Zero extra latency relative to the counters.
- Level outputs:
  - o_de = (x < H_VISIBLE) && (y < V_VISIBLE).
  - o_vblank = (y >= V_VISIBLE).
  - o_hsync = H_SYNC_ACT while x is in the h-sync window, else ~H_SYNC_ACT.
  - o_vsync = V_SYNC_ACT while y is in the v-sync window, over the whole line including its blanking, else ~V_SYNC_ACT.
- Strobes:
  - o_line_start = 1 for exactly one clk after the edge where x becomes 0.
  - o_frame_start likewise when (x,y) becomes (0,0); o_line_start is also high then.
  - Each strobe is never wider than one clk, even with i_px_clk held high.
- Reset (async assert, i_rst_n low):
  - x = H_TOTAL-1, y = V_TOTAL-1.
  - o_de = 0, o_vblank = 1, o_hsync = ~H_SYNC_ACT, o_vsync = ~V_SYNC_ACT.
  - Strobes 0, resync pending flag cleared.
  - The first tick after release therefore produces (0,0) with both strobes.
  - Reset mid-frame aborts immediately; no partial sync pulse is held.
- Resync:
  - i_resync=1 on a tick edge: next state is (0,0) with both strobes, regardless of position.
  - i_resync=1 with no tick: sets a pending flag, applied at the next tick, then cleared.
  - Resync coinciding with the natural frame wrap gives a single (0,0) entry with one strobe each.
  - Repeated resync requests before the tick collapse into one.

Test Plan:
- Default parameters, i_px_clk=1 continuously after reset release -> o_frame_start period 420000 clk. o_hsync low for exactly x=656..751 (96 clk) per line. o_vsync low for y=490..491 (1600 clk). o_de high 640 clk per line on lines 0..479 only.
- Reset release then first tick -> o_x=0, o_y=0, o_de=1, o_line_start=o_frame_start=1 for one clk. Before the tick: o_x=799, o_y=524, o_de=0, syncs high.
- Small config H=4/1/2/1, V=3/1/1/1, H_SYNC_ACT=1, i_px_clk every 3rd clk -> frame = 48 ticks = 144 clk. o_hsync high at x=5,6. o_vsync high for all of y=4. Outputs hold between ticks. Strobes are 1 clk wide.
- Assert i_resync at (x=300, y=200) on a tick -> next tick state (0,0) with o_frame_start. Assert i_resync between ticks -> applied at the following tick only.
- i_resync on the tick at (799,524) -> exactly one o_frame_start pulse.
- Drop i_rst_n during hsync (x=700) -> same cycle o_hsync=1, o_de=0, o_x=799, o_y=524 asynchronously.
